// File: rtl/axil_arbiter_wrr_rd.sv
// Weighted round-robin arbiter for the AXI-Lite read channel (AR/R) of a shared slave port.
// Define AXIL_ARB_TIMEOUT_EN to add an R-phase watchdog that forces a grant release.
module axil_arbiter_wrr_rd #(
   parameter int NUM_MASTER = 4,
   parameter int WEIGHT_W   = 4,
   parameter int TIMEOUT_W  = 8
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [NUM_MASTER-1:0]            request_rd,
   input  logic [NUM_MASTER*WEIGHT_W-1:0]   cfg_weight,
   input  logic                             s_axil_arvalid,
   input  logic                             s_axil_arready,
   input  logic                             s_axil_rvalid,
   input  logic [NUM_MASTER-1:0]            m_axil_rready,
   output logic [NUM_MASTER-1:0]            grant_rd,
   output logic [$clog2(NUM_MASTER)-1:0]    grant_idx,
   output logic                             busy,
   output logic                             timeout_err
);

   localparam int IDX_W = $clog2(NUM_MASTER);

   if (NUM_MASTER < 2) begin : g_bad_num_master
      $error("NUM_MASTER must be at least 2");
   end
   if (TIMEOUT_W < 1) begin : g_bad_timeout_w
      $error("TIMEOUT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                 state_q,       state_d;
   logic [IDX_W-1:0]       last_idx_q,    last_idx_d;
   logic [WEIGHT_W-1:0]    credit_q,      credit_d;
   logic [NUM_MASTER-1:0]  grant_rd_q,    grant_rd_d;
   logic [IDX_W-1:0]       grant_idx_q,   grant_idx_d;
   logic                   busy_q,        busy_d;

   logic [IDX_W-1:0]       cand_s;
   logic                   hit_s;
   logic                   sel_found_s;
   logic [IDX_W-1:0]       sel_idx_s;
   logic [WEIGHT_W-1:0]    sel_weight_s;
   logic                   ar_hs_s;
   logic                   r_hs_s;

`ifdef AXIL_ARB_TIMEOUT_EN
   // Release fires on the DATA cycle whose increment would bring the count to all-ones.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   logic [TIMEOUT_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
   logic                   timeout_err_q, timeout_err_d;
`endif

   assign ar_hs_s = s_axil_arvalid && s_axil_arready;
   assign r_hs_s  = s_axil_rvalid && m_axil_rready[grant_idx_q];

   // Rotating search for the first requester after last_idx, plus its weight.
   always_comb begin
      cand_s       = '0;
      hit_s        = 1'b0;
      sel_found_s  = 1'b0;
      sel_idx_s    = '0;
      sel_weight_s = '0;
      for (int k = 0; k < NUM_MASTER; k++) begin
         cand_s      = IDX_W'((int'(last_idx_q) + k + 1) % NUM_MASTER);
         hit_s       = !sel_found_s && request_rd[cand_s];
         sel_idx_s   = hit_s ? cand_s : sel_idx_s;
         sel_found_s = sel_found_s | hit_s;
      end
      for (int m = 0; m < NUM_MASTER; m++) begin
         sel_weight_s = (sel_idx_s == IDX_W'(m)) ? cfg_weight[m*WEIGHT_W +: WEIGHT_W] : sel_weight_s;
      end
   end

   // Next-state and registered-output logic of the grant FSM.
   always_comb begin
      state_d       = state_q;
      last_idx_d    = last_idx_q;
      credit_d      = credit_q;
      grant_rd_d    = grant_rd_q;
      grant_idx_d   = grant_idx_q;
`ifdef AXIL_ARB_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (sel_found_s) begin
               state_d     = ADDR;
               last_idx_d  = sel_idx_s;
               grant_idx_d = sel_idx_s;
               grant_rd_d  = {{(NUM_MASTER-1){1'b0}}, 1'b1} << sel_idx_s;
               credit_d    = (sel_weight_s == {WEIGHT_W{1'b0}}) ? {WEIGHT_W{1'b0}}
                                                                 : sel_weight_s - WEIGHT_W'(1);
            end else begin
               grant_rd_d  = '0;
               grant_idx_d = '0;
            end
         end
         ADDR: begin
            if (ar_hs_s) begin
               state_d   = DATA;
`ifdef AXIL_ARB_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end else begin
               state_d   = ADDR;
            end
         end
         DATA: begin
            // A completing R handshake always beats a watchdog expiry in the same cycle.
            if (r_hs_s) begin
               if ((credit_q != {WEIGHT_W{1'b0}}) && request_rd[grant_idx_q]) begin
                  credit_d = credit_q - WEIGHT_W'(1);
                  state_d  = ADDR;
               end else begin
                  grant_rd_d  = '0;
                  grant_idx_d = '0;
                  state_d     = IDLE;
               end
            end else begin
`ifdef AXIL_ARB_TIMEOUT_EN
               if (tmo_cnt_q == TMO_LAST) begin
                  grant_rd_d    = '0;
                  grant_idx_d   = '0;
                  credit_d      = '0;
                  tmo_cnt_d     = tmo_cnt_q + TIMEOUT_W'(1);
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  tmo_cnt_d     = tmo_cnt_q + TIMEOUT_W'(1);
               end
`else
               state_d = DATA;
`endif
            end
         end
         default: begin
            grant_rd_d  = '0;
            grant_idx_d = '0;
            credit_d    = '0;
            state_d     = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         last_idx_q    <= IDX_W'(NUM_MASTER - 1);
         credit_q      <= '0;
         grant_rd_q    <= '0;
         grant_idx_q   <= '0;
         busy_q        <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         last_idx_q    <= last_idx_d;
         credit_q      <= credit_d;
         grant_rd_q    <= grant_rd_d;
         grant_idx_q   <= grant_idx_d;
         busy_q        <= busy_d;
`ifdef AXIL_ARB_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign grant_rd  = grant_rd_q;
   assign grant_idx = grant_idx_q;
   assign busy      = busy_q;
`ifdef AXIL_ARB_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_arbiter_wrr_rd.sv
// Directed testbench for axil_arbiter_wrr_rd: hand-computed grant sequences checked with immediate assertions.
module tb_axil_arbiter_wrr_rd;

   localparam int NM = 4;
   localparam int WW = 4;
   localparam int TW = 4;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [NM-1:0]    request_rd;
   logic [NM*WW-1:0] cfg_weight;
   logic             s_axil_arvalid;
   logic             s_axil_arready;
   logic             s_axil_rvalid;
   logic [NM-1:0]    m_axil_rready;
   logic [NM-1:0]    grant_rd;
   logic [1:0]       grant_idx;
   logic             busy;
   logic             timeout_err;

   int tests = 0;
   int fails = 0;

   axil_arbiter_wrr_rd #(
      .NUM_MASTER (NM),
      .WEIGHT_W   (WW),
      .TIMEOUT_W  (TW)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .request_rd     (request_rd),
      .cfg_weight     (cfg_weight),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rvalid  (s_axil_rvalid),
      .m_axil_rready  (m_axil_rready),
      .grant_rd       (grant_rd),
      .grant_idx      (grant_idx),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_grant(input string tag, input int idx);
      check({tag, ".grant_rd"},  32'(grant_rd),  32'd1 << idx);
      check({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
      check({tag, ".busy"},      32'(busy),      32'd1);
      check({tag, ".timeout"},   32'(timeout_err), 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      check({tag, ".grant_rd"},  32'(grant_rd),  32'd0);
      check({tag, ".grant_idx"}, 32'(grant_idx), 32'd0);
      check({tag, ".busy"},      32'(busy),      32'd0);
   endtask

   // From ADDR with master idx granted: one AR handshake then one R handshake.
   task automatic read_once(input string tag, input int idx);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      chk_grant({tag, ".data"}, idx);
      s_axil_rvalid  = 1'b1;
      m_axil_rready  = 4'b0001 << idx;
      step();
      s_axil_rvalid  = 1'b0;
      m_axil_rready  = 4'b0000;
   endtask

   initial begin
      aresetn        = 1'b0;
      request_rd     = 4'b0000;
      cfg_weight     = 16'h1111;
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      s_axil_rvalid  = 1'b0;
      m_axil_rready  = 4'b0000;

      // Reset
      step();
      step();
      chk_idle("reset");
      check("reset.timeout", 32'(timeout_err), 32'd0);
      aresetn = 1'b1;
      step();
      chk_idle("no_req");

      // Two requesters, weight 1: 1,2,1,2 with a bubble after each read
      request_rd = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_grant("rr_grant", (i % 2 == 0) ? 1 : 2);
         read_once("rr_read", (i % 2 == 0) ? 1 : 2);
         if (i == 3) request_rd = 4'b0000;
         chk_idle("rr_bubble");
      end
      step();
      chk_idle("rr_stay_idle");

      // m2 weight 3: three reads without bubble, then re-grant; weight change mid-burst ignored
      cfg_weight = 16'h1311;
      request_rd = 4'b0100;
      for (int b = 0; b < 2; b++) begin
         step();
         chk_grant("w3_grant", 2);
         if (b == 1) cfg_weight = 16'h1111;
         read_once("w3_read1", 2);
         chk_grant("w3_held1", 2);
         read_once("w3_read2", 2);
         chk_grant("w3_held2", 2);
         read_once("w3_read3", 2);
         if (b == 1) request_rd = 4'b0000;
         chk_idle("w3_bubble");
      end
      step();
      chk_idle("w3_end");

      // Weight 0 behaves as 1
      cfg_weight = 16'h1110;
      request_rd = 4'b0001;
      step();
      chk_grant("w0_grant", 0);
      read_once("w0_read", 0);
      chk_idle("w0_bubble");
      step();
      chk_grant("w0_regrant", 0);
      read_once("w0_read2", 0);
      request_rd = 4'b0000;
      chk_idle("w0_bubble2");
      step();

      // m3 then wrap to m0; RREADY of another master must not complete the read
      cfg_weight = 16'h1111;
      request_rd = 4'b1001;
      step();
      chk_grant("wrap_m3", 3);
      read_once("wrap_read", 3);
      chk_idle("wrap_bubble");
      step();
      chk_grant("wrap_m0", 0);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b0;
      step();
      chk_grant("ar_wait", 0);
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      s_axil_rvalid  = 1'b1;
      m_axil_rready  = 4'b1110;
      step();
      chk_grant("wrong_rready", 0);
      m_axil_rready  = 4'b0001;
      step();
      s_axil_rvalid  = 1'b0;
      m_axil_rready  = 4'b0000;
      request_rd     = 4'b0000;
      chk_idle("wrap_done");
      step();

      // Reset during DATA with m1 granted; first grant afterwards goes to m0
      request_rd = 4'b0010;
      step();
      chk_grant("rst_m1", 1);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      chk_grant("rst_data", 1);
      aresetn    = 1'b0;
      request_rd = 4'b1111;
      step();
      chk_idle("rst_mid");
      aresetn = 1'b1;
      step();
      chk_grant("rst_first", 0);
      read_once("rst_read", 0);
      request_rd = 4'b0000;
      chk_idle("rst_done");
      step();

`ifdef AXIL_ARB_TIMEOUT_EN
      // Watchdog: 15 DATA cycles without R handshake force a release
      request_rd = 4'b0001;
      step();
      chk_grant("tmo_grant", 0);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      for (int c = 0; c < 14; c++) begin
         chk_grant("tmo_wait", 0);
         step();
      end
      chk_grant("tmo_c15", 0);
      step();
      check("tmo_pulse", 32'(timeout_err), 32'd1);
      chk_idle("tmo_release");
      step();
      chk_grant("tmo_regrant", 0);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      for (int c = 0; c < 14; c++) step();
      chk_grant("tmo_c15b", 0);
      s_axil_rvalid = 1'b1;
      m_axil_rready = 4'b0001;
      request_rd    = 4'b0000;
      step();
      s_axil_rvalid = 1'b0;
      m_axil_rready = 4'b0000;
      check("tmo_no_pulse", 32'(timeout_err), 32'd0);
      chk_idle("tmo_hs_wins");
      step();
      check("tmo_quiet", 32'(timeout_err), 32'd0);
`else
      // Without the watchdog DATA waits indefinitely
      request_rd = 4'b0001;
      step();
      chk_grant("nowd_grant", 0);
      s_axil_arvalid = 1'b1;
      s_axil_arready = 1'b1;
      step();
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      for (int c = 0; c < 40; c++) step();
      chk_grant("nowd_hold", 0);
      s_axil_rvalid = 1'b1;
      m_axil_rready = 4'b0001;
      request_rd    = 4'b0000;
      step();
      s_axil_rvalid = 1'b0;
      m_axil_rready = 4'b0000;
      chk_idle("nowd_done");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
